// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg
//   Shared definitions for the UART link sequencer:
//   - tx_state_t : TX sequencer states (3 bits)
//   - rx_state_t : RX sequencer states (2 bits)
//   - sat_inc()  : saturating increment for counters up to MAX_CNT_WD bits
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        T_IDLE = 3'd0,
        T_POP  = 3'd1,
        T_LOAD = 3'd2,
        T_WAIT = 3'd3,
        T_GAP  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_ARMED  = 2'd1,
        R_COMMIT = 2'd2
    } rx_state_t;

    localparam int unsigned MAX_CNT_WD = 32;

    // Returns value+1, holding at the all-ones value of a 'width'-bit counter.
    function automatic logic [MAX_CNT_WD-1:0] sat_inc(
        input logic [MAX_CNT_WD-1:0] value,
        input int unsigned           width
    );
        logic [MAX_CNT_WD-1:0] top;
        top = '1;
        top = top >> (MAX_CNT_WD - width);
        return (value >= top) ? top : value + 1'b1;
    endfunction

endpackage

// File: rtl/uart_sat_counter.sv
// uart_sat_counter
//   Saturating statistics counter with synchronous clear.
//   Ports:
//     clk   : system clock
//     rst   : synchronous active-high reset
//     inc   : increment request (ignored once saturated)
//     clr   : synchronous clear, wins over inc
//     count : current count, CNT_WD bits
module uart_sat_counter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [CNT_WD-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= CNT_WD'(sat_inc(MAX_CNT_WD'(count), CNT_WD));
        end
    end

endmodule

// File: rtl/uart_link_ctrl.sv
// uart_link_ctrl
//   Sequencer driving the UART TX and RX datapaths.
//   TX: pops a byte from the TX FIFO, launches the frame one cycle later,
//       waits for tx_done under a watchdog, then holds off TX_GAP cycles.
//   RX: arms the receiver, latches error flags on rx_done and commits the
//       frame to the RX FIFO, or drops it on overrun / error policy.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     tx_en, rx_en        : sequencer enables (levels)
//     drop_err_en         : discard frames with framing/parity error
//     clr_stats           : clear counters and sticky flags
//     tx_empty, tx_busy   : TX FIFO empty, transmitter busy
//     tx_done             : transmitter frame-complete pulse
//     rx_full, rx_done    : RX FIFO full, receiver frame-complete pulse
//     framing_error_flag,
//     parity_error_flag   : receiver error flags, valid with rx_done
//     tx_rd_en, tx_start  : TX FIFO pop, transmitter launch (pulses)
//     rx_start            : receiver arm (level)
//     rx_wr_en            : RX FIFO push (pulse)
//     tx_timeout          : sticky watchdog flag
//     rx_overrun          : sticky frame-lost-on-full flag
//     tx_cnt, rx_cnt,
//     drop_cnt            : saturating statistics counters
module uart_link_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned TX_GAP     = 2,
    parameter int unsigned TX_TIMEOUT = 200000,
    parameter int unsigned CNT_WD     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              rx_en,
    input  logic              drop_err_en,
    input  logic              clr_stats,
    input  logic              tx_empty,
    input  logic              tx_busy,
    input  logic              tx_done,
    input  logic              rx_full,
    input  logic              rx_done,
    input  logic              framing_error_flag,
    input  logic              parity_error_flag,
    output logic              tx_rd_en,
    output logic              tx_start,
    output logic              rx_start,
    output logic              rx_wr_en,
    output logic              tx_timeout,
    output logic              rx_overrun,
    output logic [CNT_WD-1:0] tx_cnt,
    output logic [CNT_WD-1:0] rx_cnt,
    output logic [CNT_WD-1:0] drop_cnt
);

    localparam int unsigned WD_W  = $clog2(TX_TIMEOUT + 1);
    localparam int unsigned GAP_W = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

    // ---------------- TX sequencer ----------------
    tx_state_t          tx_state, tx_next;
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               wd_last;
    logic               gap_last;
    logic               wd_fire;
    logic               tx_inc;

    assign wd_last  = (wd_cnt == WD_W'(TX_TIMEOUT - 1));
    // TX_GAP of 0 or 1 both leave T_GAP after a single cycle.
    assign gap_last = (TX_GAP <= 1) || (gap_cnt == GAP_W'(TX_GAP - 1));

    always_comb begin
        tx_next  = tx_state;
        tx_rd_en = 1'b0;
        tx_start = 1'b0;
        tx_inc   = 1'b0;
        wd_fire  = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (tx_en && !tx_empty && !tx_busy) tx_next = T_POP;
            end
            T_POP: begin
                // Guard so a pop can never be issued against an empty FIFO.
                if (tx_empty) begin
                    tx_next = T_IDLE;
                end else begin
                    tx_rd_en = 1'b1;
                    tx_next  = T_LOAD;
                end
            end
            T_LOAD: begin
                tx_start = 1'b1;
                tx_next  = T_WAIT;
            end
            T_WAIT: begin
                // Completion wins over a watchdog expiring in the same cycle.
                if (tx_done) begin
                    tx_inc  = 1'b1;
                    tx_next = T_GAP;
                end else if (wd_last) begin
                    wd_fire = 1'b1;
                    tx_next = T_IDLE;
                end
            end
            T_GAP: begin
                if (gap_last) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= T_IDLE;
            wd_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            tx_state <= tx_next;
            // Both counters run only inside their state and are zero on entry.
            wd_cnt   <= (tx_state == T_WAIT) ? wd_cnt + WD_W'(1) : '0;
            gap_cnt  <= (tx_state == T_GAP) ? gap_cnt + GAP_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            tx_timeout <= 1'b0;
        end else if (wd_fire) begin
            tx_timeout <= 1'b1;
        end
    end

    // ---------------- RX sequencer ----------------
    rx_state_t rx_state, rx_next;
    logic      err_q;
    logic      rx_inc;
    logic      drop_inc;
    logic      ovr_set;

    always_comb begin
        rx_next  = rx_state;
        rx_start = 1'b0;
        rx_wr_en = 1'b0;
        rx_inc   = 1'b0;
        drop_inc = 1'b0;
        ovr_set  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_en) rx_next = R_ARMED;
            end
            R_ARMED: begin
                rx_start = 1'b1;
                // No receiver-busy input exists; a pending rx_done is always
                // taken before honouring a dropped rx_en.
                if (rx_done) begin
                    rx_next = R_COMMIT;
                end else if (!rx_en) begin
                    rx_next = R_IDLE;
                end
            end
            R_COMMIT: begin
                if (rx_full) begin
                    ovr_set  = 1'b1;
                    drop_inc = 1'b1;
                end else if (err_q && drop_err_en) begin
                    drop_inc = 1'b1;
                end else begin
                    rx_wr_en = 1'b1;
                    rx_inc   = 1'b1;
                end
                rx_next = rx_en ? R_ARMED : R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= R_IDLE;
            err_q    <= 1'b0;
        end else begin
            rx_state <= rx_next;
            if (rx_state == R_ARMED && rx_done) begin
                err_q <= framing_error_flag | parity_error_flag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            rx_overrun <= 1'b0;
        end else if (ovr_set) begin
            rx_overrun <= 1'b1;
        end
    end

    // ---------------- Statistics ----------------
    uart_sat_counter #(.CNT_WD(CNT_WD)) u_tx_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (tx_inc),
        .clr   (clr_stats),
        .count (tx_cnt)
    );

    uart_sat_counter #(.CNT_WD(CNT_WD)) u_rx_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rx_inc),
        .clr   (clr_stats),
        .count (rx_cnt)
    );

    uart_sat_counter #(.CNT_WD(CNT_WD)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_inc),
        .clr   (clr_stats),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb_uart_link_ctrl
//   Directed bench for uart_link_ctrl with TX_GAP=2, TX_TIMEOUT=50, CNT_WD=4.
module tb_uart_link_ctrl;

    localparam int unsigned CNT_WD = 4;

    logic clk = 1'b0;
    logic rst, tx_en, rx_en, drop_err_en, clr_stats;
    logic tx_empty, tx_busy, tx_done, rx_full, rx_done;
    logic framing_error_flag, parity_error_flag;
    logic tx_rd_en, tx_start, rx_start, rx_wr_en, tx_timeout, rx_overrun;
    logic [CNT_WD-1:0] tx_cnt, rx_cnt, drop_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    uart_link_ctrl #(
        .TX_GAP     (2),
        .TX_TIMEOUT (50),
        .CNT_WD     (CNT_WD)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_en              (tx_en),
        .rx_en              (rx_en),
        .drop_err_en        (drop_err_en),
        .clr_stats          (clr_stats),
        .tx_empty           (tx_empty),
        .tx_busy            (tx_busy),
        .tx_done            (tx_done),
        .rx_full            (rx_full),
        .rx_done            (rx_done),
        .framing_error_flag (framing_error_flag),
        .parity_error_flag  (parity_error_flag),
        .tx_rd_en           (tx_rd_en),
        .tx_start           (tx_start),
        .rx_start           (rx_start),
        .rx_wr_en           (rx_wr_en),
        .tx_timeout         (tx_timeout),
        .rx_overrun         (rx_overrun),
        .tx_cnt             (tx_cnt),
        .rx_cnt             (rx_cnt),
        .drop_cnt           (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_outs"}, {26'd0, tx_rd_en, tx_start, rx_start, rx_wr_en, tx_timeout, rx_overrun}, 32'd0);
        check({tag, "_cnts"}, {20'd0, tx_cnt, rx_cnt, drop_cnt}, 32'd0);
    endtask

    // Wait (bounded) for tx_start, then complete the frame in the next cycle.
    task automatic tx_frame();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        check("tx_frame_start", {31'd0, seen}, 32'd1);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    int unsigned cnt;

    initial begin
        rst = 1'b1; tx_en = 1'b0; rx_en = 1'b0; drop_err_en = 1'b0; clr_stats = 1'b0;
        tx_empty = 1'b1; tx_busy = 1'b0; tx_done = 1'b0; rx_full = 1'b0; rx_done = 1'b0;
        framing_error_flag = 1'b0; parity_error_flag = 1'b0;
        step();
        step();
        all_zero("reset");
        rst = 1'b0;
        step();

        // Basic TX: pop, launch one cycle later, done 10 cycles after launch.
        tx_en = 1'b1; tx_empty = 1'b0;
        step();
        check("pop", {30'd0, tx_rd_en, tx_start}, 32'b10);
        step();
        check("launch", {30'd0, tx_rd_en, tx_start}, 32'b01);
        step();
        for (int i = 0; i < 9; i++) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("tx_cnt_1", tx_cnt, 32'd1);
        cnt = 0;
        for (int i = 0; i < 2; i++) begin
            if (tx_rd_en) cnt++;
            step();
        end
        if (tx_rd_en) cnt++;
        check("gap_no_pop", cnt, 32'd0);
        step();
        check("pop_after_gap", tx_rd_en, 32'd1);
        step();
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("tx_cnt_2", tx_cnt, 32'd2);

        // TX stall on empty FIFO.
        tx_empty = 1'b1;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx_rd_en || tx_start) cnt++;
        end
        check("stall_no_pulse", cnt, 32'd0);
        tx_empty = 1'b0;
        step();
        check("stall_release_pop", tx_rd_en, 32'd1);

        // Watchdog: no tx_done, flag rises 50 cycles after entering the wait.
        step();
        step();
        cnt = 0;
        for (int i = 0; i < 49; i++) begin
            step();
            if (tx_timeout) cnt++;
        end
        check("wd_not_early", cnt, 32'd0);
        tx_en = 1'b0;
        step();
        check("wd_flag", tx_timeout, 32'd1);
        check("wd_tx_cnt", tx_cnt, 32'd2);
        step();
        check("wd_idle", {30'd0, tx_rd_en, tx_start}, 32'd0);
        tx_empty = 1'b1;

        // RX commit and error policy.
        rx_en = 1'b1;
        step();
        check("rx_armed", rx_start, 32'd1);
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        check("rx_push", rx_wr_en, 32'd1);
        step();
        check("rx_push_once", rx_wr_en, 32'd0);
        check("rx_cnt_1", rx_cnt, 32'd1);

        drop_err_en = 1'b1; parity_error_flag = 1'b1; rx_done = 1'b1;
        step();
        rx_done = 1'b0; parity_error_flag = 1'b0;
        check("err_drop_nopush", rx_wr_en, 32'd0);
        step();
        check("err_drop_cnt", drop_cnt, 32'd1);
        check("err_drop_rx_cnt", rx_cnt, 32'd1);

        drop_err_en = 1'b0; parity_error_flag = 1'b1; rx_done = 1'b1;
        step();
        rx_done = 1'b0; parity_error_flag = 1'b0;
        check("err_keep_push", rx_wr_en, 32'd1);
        step();
        check("err_keep_rx_cnt", rx_cnt, 32'd2);

        // Overrun, with a framing error present to confirm priority.
        rx_full = 1'b1; drop_err_en = 1'b1; framing_error_flag = 1'b1; rx_done = 1'b1;
        step();
        rx_done = 1'b0; framing_error_flag = 1'b0;
        check("ovr_nopush", rx_wr_en, 32'd0);
        step();
        rx_full = 1'b0; drop_err_en = 1'b0;
        check("ovr_flag", rx_overrun, 32'd1);
        check("ovr_drop_cnt", drop_cnt, 32'd2);

        // Clear statistics.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr_flags", {30'd0, tx_timeout, rx_overrun}, 32'd0);
        check("clr_cnts", {20'd0, tx_cnt, rx_cnt, drop_cnt}, 32'd0);

        // Clear coinciding with a push: clear wins.
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        check("clr_race_push", rx_wr_en, 32'd1);
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        check("clr_race_cnt", rx_cnt, 32'd0);

        // Reset with TX in T_WAIT and RX in R_COMMIT.
        tx_en = 1'b1; tx_empty = 1'b0;
        step();
        step();
        step();
        rx_done = 1'b1;
        step();
        rx_done = 1'b0;
        check("pre_rst_commit", rx_wr_en, 32'd1);
        rst = 1'b1; tx_done = 1'b1;
        step();
        rst = 1'b0; tx_done = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
        all_zero("mid_rst");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_rd_en || tx_start || rx_wr_en || rx_start) cnt++;
        end
        check("no_late_pulse", cnt, 32'd0);
        check("rst_cnts", {20'd0, tx_cnt, rx_cnt, drop_cnt}, 32'd0);

        // Saturation at 15 for a 4-bit counter.
        tx_en = 1'b1; tx_empty = 1'b0;
        for (int i = 0; i < 14; i++) tx_frame();
        check("sat_pre", tx_cnt, 32'd14);
        for (int i = 0; i < 6; i++) tx_frame();
        check("sat_hold", tx_cnt, 32'd15);
        tx_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
